// File: rtl/fp_operand_unpack.sv
// fp_operand_unpack: two-stage IEEE 754 operand unpacker; S1 classifies, S2 normalizes.
// fp_classify_operand is the combinational field classifier feeding the S1 slot.

module fp_classify_operand #(
  parameter int EXP_BITS  = 8,
  parameter int FRAC_BITS = 23
) (
  input  logic [EXP_BITS-1:0]  i_exp,
  input  logic [FRAC_BITS-1:0] i_frac,
  output logic                 o_is_zero,
  output logic                 o_is_subnormal,
  output logic                 o_is_inf,
  output logic                 o_is_nan,
  output logic                 o_is_snan
);
  logic exp_zero;
  logic exp_ones;
  logic frac_zero;

  assign exp_zero  = (i_exp == '0);
  assign exp_ones  = &i_exp;
  assign frac_zero = (i_frac == '0);

  assign o_is_zero      = exp_zero && frac_zero;
  assign o_is_subnormal = exp_zero && !frac_zero;
  assign o_is_inf       = exp_ones && frac_zero;
  assign o_is_nan       = exp_ones && !frac_zero;
  // fraction MSB is the quiet bit
  assign o_is_snan      = exp_ones && !frac_zero && !i_frac[FRAC_BITS-1];
endmodule

module fp_operand_unpack #(
  parameter int EXP_BITS  = 8,
  parameter int FRAC_BITS = 23
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [EXP_BITS+FRAC_BITS:0]     i_operand,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_sign,
  output logic [EXP_BITS+1:0]             o_exp,
  output logic [FRAC_BITS:0]              o_mant,
  output logic                            o_is_zero,
  output logic                            o_is_subnormal,
  output logic                            o_is_inf,
  output logic                            o_is_nan,
  output logic                            o_is_snan
);
  localparam int EW  = EXP_BITS + 2;
  localparam int LZW = $clog2(FRAC_BITS + 1);
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_BITS - 1)) - 1);

  // class vector layout: {zero, subnormal, inf, nan, snan}
  logic [4:0]           cls_w;
  logic                 s2_free;
  logic                 s1_advance;
  logic                 in_xfer;
  logic [LZW-1:0]       lz;
  logic                 lz_found;

  logic                 s1_valid_d, s1_valid_q;
  logic                 s1_sign_d,  s1_sign_q;
  logic [EXP_BITS-1:0]  s1_exp_d,   s1_exp_q;
  logic [FRAC_BITS-1:0] s1_frac_d,  s1_frac_q;
  logic [4:0]           s1_cls_d,   s1_cls_q;

  logic                 s2_valid_d, s2_valid_q;
  logic                 s2_sign_d,  s2_sign_q;
  logic [EW-1:0]        s2_exp_d,   s2_exp_q;
  logic [FRAC_BITS:0]   s2_mant_d,  s2_mant_q;
  logic [4:0]           s2_cls_d,   s2_cls_q;

  fp_classify_operand #(
    .EXP_BITS  (EXP_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_classify (
    .i_exp          (i_operand[FRAC_BITS +: EXP_BITS]),
    .i_frac         (i_operand[FRAC_BITS-1:0]),
    .o_is_zero      (cls_w[4]),
    .o_is_subnormal (cls_w[3]),
    .o_is_inf       (cls_w[2]),
    .o_is_nan       (cls_w[1]),
    .o_is_snan      (cls_w[0])
  );

  assign s2_free    = !s2_valid_q || i_ready;
  assign s1_advance = s1_valid_q && s2_free;
  assign o_ready    = !s1_valid_q || s1_advance;
  assign in_xfer    = i_valid && o_ready;

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = FRAC_BITS - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (s1_frac_q[i]) lz_found = 1'b1;
        else              lz = lz + LZW'(1);
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_frac_d  = s1_frac_q;
    s1_cls_d   = s1_cls_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_sign_d  = i_operand[EXP_BITS+FRAC_BITS];
      s1_exp_d   = i_operand[FRAC_BITS +: EXP_BITS];
      s1_frac_d  = i_operand[FRAC_BITS-1:0];
      s1_cls_d   = cls_w;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_free ? s1_advance : s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_exp_d   = s2_exp_q;
    s2_mant_d  = s2_mant_q;
    s2_cls_d   = s2_cls_q;
    if (s1_advance) begin
      s2_sign_d = s1_sign_q;
      s2_cls_d  = s1_cls_q;
      if (s1_cls_q[4]) begin
        s2_exp_d  = '0;
        s2_mant_d = '0;
      end else if (s1_cls_q[3]) begin
        // shift the leading one into the integer bit position
        s2_exp_d  = '0 - BIAS - EW'(lz);
        s2_mant_d = {1'b0, s1_frac_q} << (lz + LZW'(1));
      end else if (s1_cls_q[2] || s1_cls_q[1]) begin
        s2_exp_d  = BIAS + EW'(1);
        s2_mant_d = {1'b0, s1_frac_q};
      end else begin
        s2_exp_d  = EW'(s1_exp_q) - BIAS;
        s2_mant_d = {1'b1, s1_frac_q};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_frac_q  <= '0;
      s1_cls_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_mant_q  <= '0;
      s2_cls_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_frac_q  <= s1_frac_d;
      s1_cls_q   <= s1_cls_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_exp_q   <= s2_exp_d;
      s2_mant_q  <= s2_mant_d;
      s2_cls_q   <= s2_cls_d;
    end
  end

  assign o_valid        = s2_valid_q;
  assign o_sign         = s2_sign_q;
  assign o_exp          = s2_exp_q;
  assign o_mant         = s2_mant_q;
  assign o_is_zero      = s2_cls_q[4];
  assign o_is_subnormal = s2_cls_q[3];
  assign o_is_inf       = s2_cls_q[2];
  assign o_is_nan       = s2_cls_q[1];
  assign o_is_snan      = s2_cls_q[0];
endmodule

// File: tb/tb_fp_operand_unpack.sv
// Bench for fp_operand_unpack: directed FP32 vectors, backpressure, mid-flight reset,
// a random stream against a shift-loop model, and an FP64 instance for the minimum subnormal.

module tb_fp_operand_unpack;
  typedef struct packed {
    logic        sign;
    logic [9:0]  e;
    logic [23:0] m;
    logic [4:0]  f;
  } res_t;

  localparam logic [4:0] F_ZERO = 5'b10000;
  localparam logic [4:0] F_SUB  = 5'b01000;
  localparam logic [4:0] F_INF  = 5'b00100;
  localparam logic [4:0] F_NAN  = 5'b00010;
  localparam logic [4:0] F_SNAN = 5'b00001;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_operand = '0;
  logic        i_ready = 1'b1;
  logic        o_ready, o_valid, o_sign;
  logic [9:0]  o_exp;
  logic [23:0] o_mant;
  logic        o_is_zero, o_is_subnormal, o_is_inf, o_is_nan, o_is_snan;

  logic        d_valid = 1'b0;
  logic [63:0] d_operand = '0;
  logic        d_o_ready, d_o_valid, d_o_sign;
  logic [12:0] d_o_exp;
  logic [52:0] d_o_mant;
  logic        d_zero, d_sub, d_inf, d_nan, d_snan;

  int   n_checks = 0;
  int   n_fail = 0;
  res_t exp_q[$];
  res_t cur_exp;
  res_t got;
  res_t held;

  always #5 i_clk = ~i_clk;

  fp_operand_unpack dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_operand(i_operand), .o_valid(o_valid), .i_ready(i_ready),
    .o_sign(o_sign), .o_exp(o_exp), .o_mant(o_mant),
    .o_is_zero(o_is_zero), .o_is_subnormal(o_is_subnormal), .o_is_inf(o_is_inf),
    .o_is_nan(o_is_nan), .o_is_snan(o_is_snan)
  );

  fp_operand_unpack #(.EXP_BITS(11), .FRAC_BITS(52)) dut64 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(d_valid), .o_ready(d_o_ready),
    .i_operand(d_operand), .o_valid(d_o_valid), .i_ready(1'b1),
    .o_sign(d_o_sign), .o_exp(d_o_exp), .o_mant(d_o_mant),
    .o_is_zero(d_zero), .o_is_subnormal(d_sub), .o_is_inf(d_inf),
    .o_is_nan(d_nan), .o_is_snan(d_snan)
  );

  assign got = '{sign: o_sign, e: o_exp, m: o_mant,
                 f: {o_is_zero, o_is_subnormal, o_is_inf, o_is_nan, o_is_snan}};

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic res_t mk(input bit s, input int e, input logic [23:0] m, input logic [4:0] f);
    res_t r;
    r.sign = s;
    r.e    = e[9:0];
    r.m    = m;
    r.f    = f;
    return r;
  endfunction

  // Reference: renormalize subnormals by shifting one bit at a time
  function automatic res_t model(input logic [31:0] x);
    logic [7:0]  ex;
    logic [22:0] fr;
    logic [23:0] m;
    logic [4:0]  f;
    int          e;
    ex = x[30:23];
    fr = x[22:0];
    f  = '0;
    if (ex == 8'hFF) begin
      e = 128;
      m = {1'b0, fr};
      if (fr == '0) f = F_INF;
      else          f = fr[22] ? F_NAN : (F_NAN | F_SNAN);
    end else if (ex == 8'h00) begin
      if (fr == '0) begin
        e = 0;
        m = '0;
        f = F_ZERO;
      end else begin
        e = -126;
        m = {1'b0, fr};
        while (!m[23]) begin
          m = m << 1;
          e--;
        end
        f = F_SUB;
      end
    end else begin
      e = int'(ex) - 127;
      m = {1'b1, fr};
    end
    return mk(x[31], e, m, f);
  endfunction

  // Scoreboard: outputs are compared in order at the handshake that takes them
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 64'(got), 64'hDEAD);
      else check("out", 64'(got), 64'(exp_q.pop_front()));
    end
    if (i_rst) exp_q.delete();
    else if (i_valid && o_ready) exp_q.push_back(cur_exp);
  end

  task automatic send(input logic [31:0] op, input res_t e);
    bit ok;
    ok = 1'b0;
    i_valid   = 1'b1;
    i_operand = op;
    cur_exp   = e;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge i_clk);
      ok = o_ready;
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge i_clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 0);
  endtask

  logic [31:0] dir_op [10];
  res_t        dir_exp[10];
  bit          rnd_on;
  logic [31:0] r;

  initial begin
    dir_op[0] = 32'h3F800000; dir_exp[0] = mk(0, 0,    24'h800000, 5'b0);
    dir_op[1] = 32'h00000001; dir_exp[1] = mk(0, -149, 24'h800000, F_SUB);
    dir_op[2] = 32'h80400000; dir_exp[2] = mk(1, -127, 24'h800000, F_SUB);
    dir_op[3] = 32'h7F800001; dir_exp[3] = mk(0, 128,  24'h000001, F_NAN | F_SNAN);
    dir_op[4] = 32'h7FC00000; dir_exp[4] = mk(0, 128,  24'h400000, F_NAN);
    dir_op[5] = 32'hFF800000; dir_exp[5] = mk(1, 128,  24'h000000, F_INF);
    dir_op[6] = 32'h00000000; dir_exp[6] = mk(0, 0,    24'h000000, F_ZERO);
    dir_op[7] = 32'h007FFFFF; dir_exp[7] = mk(0, -127, 24'hFFFFFE, F_SUB);
    dir_op[8] = 32'h00800000; dir_exp[8] = mk(0, -126, 24'h800000, 5'b0);
    dir_op[9] = 32'h40490FDB; dir_exp[9] = mk(0, 1,    24'hC90FDB, 5'b0);

    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("rst_o_valid", 64'(o_valid), 0);
    check("rst_o_ready", 64'(o_ready), 1);
    check("rst_data",    64'(got),     0);

    // Latency: presented now, visible after the second edge
    i_valid = 1'b1; i_operand = 32'h3F800000; cur_exp = dir_exp[0];
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    check("lat_edge1_valid", 64'(o_valid), 0);
    @(posedge i_clk); #1;
    check("lat_edge2_valid", 64'(o_valid), 1);
    check("lat_one",         64'(got), 64'(dir_exp[0]));
    drain();

    foreach (dir_op[k]) send(dir_op[k], dir_exp[k]);
    drain();

    // Backpressure: two operands fill both slots, then outputs must hold
    i_ready = 1'b0;
    send(32'h3F800000, dir_exp[0]);
    send(32'h80400000, dir_exp[2]);
    check("bp_o_ready_low", 64'(o_ready), 0);
    check("bp_o_valid",     64'(o_valid), 1);
    held = got;
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      check("bp_hold", 64'(got), 64'(held));
      check("bp_o_ready_held", 64'(o_ready), 0);
    end
    i_ready = 1'b1;
    send(32'h7F800001, dir_exp[3]);
    send(32'h007FFFFF, dir_exp[7]);
    send(32'h40490FDB, dir_exp[9]);
    drain();

    // Reset with both slots full and an offered operand
    i_ready = 1'b0;
    send(32'h3F800000, dir_exp[0]);
    send(32'h00000001, dir_exp[1]);
    check("rf_full", 64'(o_ready), 0);
    i_valid = 1'b1; i_operand = 32'hFF800000; cur_exp = dir_exp[5];
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_valid = 1'b0;
    check("rf_o_valid", 64'(o_valid), 0);
    check("rf_o_ready", 64'(o_ready), 1);
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk); #1;
      check("rf_no_stale", 64'(o_valid), 0);
    end

    // Random stream with random downstream ready
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge i_clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int n = 0; n < 2000; n++) begin
          r = $urandom;
          case ($urandom_range(0, 5))
            0: r[30:23] = 8'h00;
            1: r[30:23] = 8'hFF;
            2: r = {r[31], 8'h00, 23'(1) << $urandom_range(0, 22)};
            default: ;
          endcase
          send(r, model(r));
        end
        rnd_on = 1'b0;
      end
    join
    i_ready = 1'b1;
    drain();

    // FP64 instance: minimum subnormal, then 1.0 back to back
    d_valid = 1'b1; d_operand = 64'h0000000000000001;
    @(posedge i_clk); #1;
    d_operand = 64'h3FF0000000000000;
    @(posedge i_clk); #1;
    d_valid = 1'b0;
    check("d_valid0", 64'(d_o_valid), 1);
    check("d_minsub_exp",  64'(d_o_exp), 64'(13'h1BCE));
    check("d_minsub_mant", 64'(d_o_mant), 64'h0010000000000000);
    check("d_minsub_flag", 64'({d_zero, d_sub, d_inf, d_nan, d_snan}), 64'(F_SUB));
    @(posedge i_clk); #1;
    check("d_valid1", 64'(d_o_valid), 1);
    check("d_one_exp",  64'(d_o_exp), 0);
    check("d_one_mant", 64'(d_o_mant), 64'h0010000000000000);
    check("d_one_flag", 64'({d_o_sign, d_zero, d_sub, d_inf, d_nan, d_snan}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
